jtmx5k_gfxrom_cache: RTL
========================

Name: jtmx5k_gfxrom_cache

Overview:
Sits between the gfx1 tile/object ROM port of the MX5000 video stage and the SDRAM controller slot. It turns the gfx engine's level-style address/cs interface into single-word SDRAM read transactions. A 2-entry fully-associative word cache removes repeat fetches of the same word. It returns rom_data/rom_ok in the form the gfx engine expects.

Parameters:
AW, 18, gfx word address width
DW, 16, data width
SAW, 22, SDRAM word address width
ROM_OFFSET, 22'h0, SDRAM base of gfx1 region; added to rom_addr

Ports:
clk  in  1  system clock (48 MHz)
rst  in  1  asynchronous, active-high reset
rom_cs  in  1  gfx engine requests data at rom_addr
rom_addr  in  AW  gfx word address
rom_data  out  DW  data for rom_addr, valid when rom_ok=1
rom_ok  out  1  rom_data matches current rom_addr
flush  in  1  one-cycle pulse; invalidates cache (bank switch / ROM download end)
sdram_req  out  1  read request to SDRAM slot
sdram_addr  out  SAW  SDRAM word address, held stable while sdram_req=1
sdram_ack  in  1  one-cycle pulse; controller accepted request
sdram_dst  in  1  one-cycle pulse; sdram_dout valid
sdram_dout  in  DW  SDRAM read data

Behaviour:
- Reset (async, rst=1): both entries invalid, tags/data 0, LRU=0, FSM=IDLE, sdram_req=0, sdram_addr=0. rom_ok=0 and rom_data=0.
- Hit: combinational. rom_ok = rom_cs && entry valid && tag==rom_addr. rom_data is muxed from the hitting entry. rom_data is 0 when there is no hit. A hit updates LRU at the next edge to point at the other entry.
- FSM IDLE: if rom_cs && !hit && !flush, latch rom_addr into req_tag. Drive sdram_addr = ROM_OFFSET + zero-extended rom_addr (mod 2^SAW) and sdram_req=1. Go to REQ.
- FSM REQ: hold sdram_req and sdram_addr. On sdram_ack, set sdram_req=0 and go to WAIT.
- FSM WAIT: on sdram_dst, write sdram_dout and req_tag into the LRU entry and set it valid. Set LRU to the other entry and go to IDLE. If sdram_dst arrives in the same cycle as sdram_ack (while in REQ), complete directly to IDLE.
- Miss latency: rom_ok rises the cycle after the fill edge at the earliest. That is 1 (req) + controller ack/dst latency + 1.
- Only one transaction is outstanding at a time. There are no back-to-back requests without passing through IDLE, so each miss occupies at least 1 idle cycle.
- Address change mid-fetch: the in-flight fetch completes and fills under req_tag. The new address is evaluated in IDLE and may start another miss.
- rom_cs dropping mid-fetch: the fetch completes and fills. No new request is issued while rom_cs=0.
- flush: clears both valid bits at the next edge. If a fetch is in flight, its fill is discarded; the valid bit stays 0 via a sticky drop flag cleared on return to IDLE. The SDRAM handshake still completes. A flush in IDLE in the same cycle as a miss suppresses the request for that cycle.
- Duplicate protection: an entry is never filled with a tag already valid in the other entry. If that would happen, the fill overwrites the matching entry instead.
- Reset mid-transaction: everything returns to reset state immediately. A later stray sdram_dst in IDLE is ignored.

Decomposition:
- Shared package jtmx5k_pkg: FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2) and the entry count constant (2).
- One sub-module, jtmx5k_cache_entry: holds valid/tag/data for one entry, with async clear, fill, invalidate and tag-compare output.
- The top level holds the FSM, LRU bit, hit mux and address adder.

Test Plan:
- Cold miss: rst release, rom_cs=1, rom_addr=18'h00123, ROM_OFFSET=22'h080000 -> sdram_req=1 and sdram_addr=22'h080123 next cycle. Ack at +2 and dst at +4 with dout=16'hBEEF -> rom_ok=1, rom_data=16'hBEEF on the cycle after dst.
- Hit: re-present 18'h00123 after another address -> rom_ok=1 combinationally with 16'hBEEF, and sdram_req is never asserted.
- LRU replace: fill A=0x10 and B=0x20, hit A, then miss C=0x30 -> C evicts B. Re-access of A hits; re-access of B issues a new sdram_req.
- Address change mid-fetch: switch rom_addr from 0x40 to 0x50 while in WAIT -> 0x40 is filled, then a second request with sdram_addr=OFFSET+0x50 follows. rom_ok stays 0 for 0x50 until its own dst.
- Flush mid-fetch: pulse flush in WAIT -> the dst is consumed, rom_ok stays 0, and a re-request of the same address follows.
- Async reset in REQ: assert rst between clock edges -> sdram_req=0 and rom_ok=0 immediately. A stray dst after rst release produces no fill.

Source files
------------

// File: rtl/jtmx5k_pkg.sv
// Shared definitions for the MX5000 gfx1 ROM cache.
//   state_e    : transaction FSM encoding (IDLE/REQ/WAIT)
//   NumEntries : number of fully-associative cache entries
package jtmx5k_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_e;

  localparam int unsigned NumEntries = 2;

endpackage

// File: rtl/jtmx5k_cache_entry.sv
// One cache line: valid bit, word tag and data word.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears valid/tag/data)
//   inval      : clear valid at the next edge (wins over fill)
//   fill       : load fill_tag/fill_data and set valid
//   cmp_addr   : address compared against the stored tag
//   valid, tag, data : stored contents
//   match      : valid && tag == cmp_addr
module jtmx5k_cache_entry #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inval,
  input  logic          fill,
  input  logic [AW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  input  logic [AW-1:0] cmp_addr,
  output logic          valid,
  output logic [AW-1:0] tag,
  output logic [DW-1:0] data,
  output logic          match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign match = valid && (tag == cmp_addr);

endmodule

// File: rtl/jtmx5k_gfxrom_cache.sv
// Two-entry word cache between the gfx1 ROM port and an SDRAM read slot.
// Converts the level-style rom_cs/rom_addr request into single-word SDRAM reads.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   rom_cs, rom_addr         : gfx engine request
//   rom_data, rom_ok         : combinational hit result (rom_data is 0 without a hit)
//   flush                    : one-cycle pulse, invalidates all entries
//   sdram_req, sdram_addr    : registered read request, held until sdram_ack
//   sdram_ack                : controller accepted the request
//   sdram_dst, sdram_dout    : read data strobe and data
module jtmx5k_gfxrom_cache
  import jtmx5k_pkg::*;
#(
  parameter int unsigned   AW         = 18,
  parameter int unsigned   DW         = 16,
  parameter int unsigned   SAW        = 22,
  parameter logic [SAW-1:0] ROM_OFFSET = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [DW-1:0]  rom_data,
  output logic           rom_ok,
  input  logic           flush,
  output logic           sdram_req,
  output logic [SAW-1:0] sdram_addr,
  input  logic           sdram_ack,
  input  logic           sdram_dst,
  input  logic [DW-1:0]  sdram_dout
);

  state_e                 state;
  logic [AW-1:0]          req_tag;
  logic                   drop;   // fill of the in-flight fetch must be discarded
  logic                   lru;    // entry to replace on the next fill

  logic [NumEntries-1:0]  ent_valid;
  logic [NumEntries-1:0]  ent_match;
  logic [NumEntries-1:0]  ent_fill;
  logic [AW-1:0]          ent_tag  [NumEntries];
  logic [DW-1:0]          ent_data [NumEntries];

  logic [NumEntries-1:0]  hit_vec;
  logic                   hit;
  logic                   done;
  logic                   fill_go;
  logic                   fill_idx;

  for (genvar i = 0; i < NumEntries; i++) begin : g_entry
    jtmx5k_cache_entry #(
      .AW (AW),
      .DW (DW)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .inval     (flush),
      .fill      (ent_fill[i]),
      .fill_tag  (req_tag),
      .fill_data (sdram_dout),
      .cmp_addr  (rom_addr),
      .valid     (ent_valid[i]),
      .tag       (ent_tag[i]),
      .data      (ent_data[i]),
      .match     (ent_match[i])
    );
    assign ent_fill[i] = fill_go && (fill_idx == 1'(i));
  end

  assign hit_vec = ent_match & {NumEntries{rom_cs}};
  assign hit     = |hit_vec;
  assign rom_ok  = hit;

  always_comb begin
    rom_data = '0;
    for (int i = 0; i < NumEntries; i++) begin
      if (hit_vec[i]) rom_data = ent_data[i];
    end
  end

  // Data return either together with the ack or later while waiting
  assign done    = ((state == StReq) && sdram_ack && sdram_dst) ||
                   ((state == StWait) && sdram_dst);
  assign fill_go = done && !drop && !flush;

  // Never create a duplicate tag: refill the entry already holding req_tag
  always_comb begin
    fill_idx = lru;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_tag[i] == req_tag)) fill_idx = 1'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru <= 1'b0;
    end else if (fill_go) begin
      lru <= ~fill_idx;
    end else if (hit) begin
      lru <= hit_vec[0];  // hit on entry 0 -> replace 1 next, and vice versa
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      req_tag    <= '0;
      drop       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          drop <= 1'b0;
          if (rom_cs && !hit && !flush) begin
            req_tag    <= rom_addr;
            sdram_addr <= ROM_OFFSET + SAW'(rom_addr);
            sdram_req  <= 1'b1;
            state      <= StReq;
          end
        end
        StReq: begin
          if (flush) drop <= 1'b1;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (sdram_dst) begin
              state <= StIdle;
              drop  <= 1'b0;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          if (flush) drop <= 1'b1;
          if (sdram_dst) begin
            state <= StIdle;
            drop  <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
